// File: rtl/row_buffer_writer_pkg.sv
// Shared types and helpers for the row buffer writer.
// Optional build macro used by the top level: ROW_BUF_ERR_CHECK_EN.
package row_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_t;

    // Width needed to count 0..num_rows completed rows.
    function automatic int rows_width(input int num_rows);
        return $clog2(num_rows + 1);
    endfunction

    // First address of a row slot inside the buffer region.
    function automatic int row_base(input int offset, input int row, input int row_len);
        return offset + (row * row_len);
    endfunction

endpackage

// File: rtl/row_buffer_writer_if.sv
// Producer stream, memory write port and row-occupancy handshake of the row buffer writer.
interface row_buffer_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RW         = 3
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  row_done;
    logic                  row_release;
    logic [RW-1:0]         rows_avail;
    logic                  full;

    // Producer / memory / reader side.
    modport master (
        output in_valid, in_data, row_release,
        input  in_ready, wr_en, wr_addr, wr_data, row_done, rows_avail, full
    );

    // Writer side.
    modport slave (
        input  in_valid, in_data, row_release,
        output in_ready, wr_en, wr_addr, wr_data, row_done, rows_avail, full
    );
endinterface

// File: rtl/row_buffer_writer_mod_counter.sv
// Modulo-MOD counter with synchronous clear; wrap flags the enabled step from MOD-1 back to 0.
module mod_counter #(
    parameter int MOD = 4,
    localparam int W  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    logic [W-1:0] count_r;

    assign count = count_r;
    assign wrap  = en && (count_r == W'(MOD - 1));

    // Count register: clear dominates, wrap returns to zero, otherwise step on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (wrap) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/row_buffer_writer.sv
// Write-side controller for row-organised scratchpad buffers.
// Writes each accepted beat at OFFSET + row*ROW_LEN + col, pulses row_done per row,
// tracks completed-but-unread rows and back-pressures the producer when all slots are full.
// Define ROW_BUF_ERR_CHECK_EN to add the sticky err output (underflow release / stall watchdog).
module row_buffer_writer
    import row_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OFFSET     = 0,
    parameter int ROW_LEN    = 3,
    parameter int NUM_ROWS   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    row_buffer_writer_if.slave bus
`ifdef ROW_BUF_ERR_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int RW  = rows_width(NUM_ROWS);
    localparam int CW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int RCW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [RW-1:0] ROWS_MAX = RW'(NUM_ROWS);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [RW-1:0]           rows_avail_r;
    logic [RW-1:0]           rows_next_s;
    logic                    full_r;
    logic                    wr_en_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]   wr_data_r;
    logic                    row_done_r;
    logic [CW-1:0]           col_s;
    logic [RCW-1:0]          row_s;
    logic                    col_wrap_s;
    logic                    accept_s;
    logic                    in_ready_s;
    logic                    release_ok_s;

    // Ready is taken from registered state; a start cycle always drops its beat.
    assign in_ready_s   = (state_r == RUN) && !full_r && !start;
    assign accept_s     = bus.in_valid && in_ready_s;
    // A release with nothing to consume is ignored so the count saturates at zero.
    assign release_ok_s = bus.row_release && (rows_avail_r != '0);

    assign bus.in_ready   = in_ready_s;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.row_done   = row_done_r;
    assign bus.rows_avail = rows_avail_r;
    assign bus.full       = full_r;

    mod_counter #(.MOD(ROW_LEN)) u_col (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (accept_s),
        .count (col_s),
        .wrap  (col_wrap_s)
    );

    mod_counter #(.MOD(NUM_ROWS)) u_row (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (col_wrap_s),
        .count (row_s),
        .wrap  ()
    );

    // Occupancy update and next-state selection.
    always_comb begin
        rows_next_s  = rows_avail_r;
        state_next_s = state_r;
        if (start) begin
            rows_next_s = '0;
        end else if (col_wrap_s && !release_ok_s) begin
            rows_next_s = rows_avail_r + RW'(1'b1);
        end else if (!col_wrap_s && release_ok_s) begin
            rows_next_s = rows_avail_r - RW'(1'b1);
        end else begin
            rows_next_s = rows_avail_r;
        end
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (start)                        state_next_s = RUN;
                else if (rows_next_s == ROWS_MAX) state_next_s = FULL;
                else                              state_next_s = RUN;
            end
            FULL: begin
                if (start)             state_next_s = RUN;
                else if (release_ok_s) state_next_s = RUN;
                else                   state_next_s = FULL;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, occupancy and full flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            rows_avail_r <= '0;
            full_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            rows_avail_r <= rows_next_s;
            full_r       <= (rows_next_s == ROWS_MAX);
        end
    end

    // Registered memory write port; address and data hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_WIDTH'(OFFSET);
            wr_data_r  <= '0;
            row_done_r <= 1'b0;
        end else begin
            wr_en_r    <= accept_s;
            row_done_r <= col_wrap_s;
            if (accept_s) begin
                wr_addr_r <= ADDR_WIDTH'(row_base(OFFSET, int'(row_s), ROW_LEN) + int'(col_s));
                wr_data_r <= bus.in_data;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

`ifdef ROW_BUF_ERR_CHECK_EN
    localparam int LIMIT = NUM_ROWS * ROW_LEN;
    localparam int WDW   = $clog2(LIMIT + 1);

    logic [WDW-1:0] wd_cnt_r;
    logic           err_r;
    logic           stall_s;

    assign stall_s = bus.in_valid && (state_r == FULL);
    assign err     = err_r;

    // Sticky error: underflow release, or producer stalled in FULL beyond one full buffer of cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= '0;
            err_r    <= 1'b0;
        end else if (start) begin
            wd_cnt_r <= '0;
            err_r    <= 1'b0;
        end else begin
            if (stall_s) begin
                wd_cnt_r <= (wd_cnt_r == WDW'(LIMIT)) ? wd_cnt_r : wd_cnt_r + WDW'(1'b1);
            end else begin
                wd_cnt_r <= '0;
            end
            if ((bus.row_release && (rows_avail_r == '0)) ||
                (stall_s && (wd_cnt_r == WDW'(LIMIT)))) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_row_buffer_writer.sv
// Randomised self-checking bench for row_buffer_writer against a slot/occupancy reference model.
module tb_row_buffer_writer;
    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int OFFSET = 16;
    localparam int RL     = 3;
    localparam int NR     = 4;
    localparam int RW     = 3;
    localparam int LIMIT  = NR * RL;

    logic clk = 1'b0;
    logic reset;
    logic start;
`ifdef ROW_BUF_ERR_CHECK_EN
    logic err;
`endif

    always #5 clk = ~clk;

    row_buffer_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW(RW)) bus ();

    row_buffer_writer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .OFFSET     (OFFSET),
        .ROW_LEN    (RL),
        .NUM_ROWS   (NR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus)
`ifdef ROW_BUF_ERR_CHECK_EN
        ,
        .err   (err)
`endif
    );

    // Reference model: total beats written into the region and rows waiting for the reader.
    int            beat_m;
    int            avail_m;
    int            wd_m;
    bit            run_m;
    bit            err_m;
    logic          exp_wr_en;
    logic          exp_done;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_ready;
    logic          act_ready;

    int tests = 0;
    int fails = 0;

    function automatic logic [30:0] obs_vec();
        return {bus.wr_en, bus.wr_addr, bus.wr_data, bus.row_done, bus.rows_avail, bus.full, act_ready};
    endfunction

    function automatic logic [30:0] exp_vec();
        logic f;
        f = (avail_m == NR);
        return {exp_wr_en, exp_addr, exp_data, exp_done, RW'(avail_m), f, exp_ready};
    endfunction

    task automatic model_reset();
        beat_m    = 0;
        avail_m   = 0;
        wd_m      = 0;
        run_m     = 1'b0;
        err_m     = 1'b0;
        exp_wr_en = 1'b0;
        exp_done  = 1'b0;
        exp_addr  = AW'(OFFSET);
        exp_data  = '0;
        exp_ready = 1'b0;
    endtask

    // Drive one cycle of inputs, sample ready before the edge, advance the model at the edge.
    task automatic step(input bit st, input bit v, input logic [DW-1:0] d, input bit rel);
        bit acc;
        bit done;
        bit stalled;
        @(negedge clk);
        start           = st;
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.row_release = rel;
        #1;
        act_ready = bus.in_ready;
        exp_ready = run_m && (avail_m < NR) && !st;
        @(posedge clk);
        acc     = v && exp_ready;
        done    = 1'b0;
        stalled = run_m && (avail_m == NR) && v && !st;
        exp_wr_en = acc;
        if (acc) begin
            exp_addr = AW'(OFFSET + beat_m);
            exp_data = d;
            beat_m   = (beat_m + 1) % (RL * NR);
            done     = ((beat_m % RL) == 0);
        end
        exp_done = done;
        if (stalled) begin
            if (wd_m == LIMIT) err_m = 1'b1;
            else               wd_m = wd_m + 1;
        end else begin
            wd_m = 0;
        end
        if (rel && avail_m == 0) err_m = 1'b1;
        if (rel && avail_m > 0) avail_m = avail_m - 1;
        if (done) avail_m = avail_m + 1;
        if (st) begin
            beat_m  = 0;
            avail_m = 0;
            run_m   = 1'b1;
            err_m   = 1'b0;
            wd_m    = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.row_release = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        act_ready = bus.in_ready;
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_values: got %h expected %h", obs_vec(), exp_vec());
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL idle_no_accept %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_row();
        step(1'b1, 1'b1, 16'($urandom), 1'b0);
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL single_row_start: got %h expected %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i < 3), 16'($urandom), 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL single_row beat %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (bus.rows_avail !== 3'd1) begin
            fails++;
            $display("FAIL single_row_avail: got %0d expected 1", bus.rows_avail);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] held;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL fill beat %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (bus.full !== 1'b1 || bus.rows_avail !== 3'd4 || bus.wr_addr !== 8'd27) begin
            fails++;
            $display("FAIL fill_full: got full=%b avail=%0d addr=%0d expected 1 4 27", bus.full, bus.rows_avail, bus.wr_addr);
        end
        held = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, held, 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL fill_hold %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        step(1'b0, 1'b1, held, 1'b1);
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL fill_release: got %h expected %h", obs_vec(), exp_vec());
        end
        step(1'b0, 1'b1, held, 1'b0);
        tests++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd16 || bus.wr_data !== held) begin
            fails++;
            $display("FAIL fill_wrap_write: got en=%b addr=%0d data=%h expected 1 16 %h", bus.wr_en, bus.wr_addr, bus.wr_data, held);
        end
    endtask

    task automatic test_same_edge();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, (i < 6), 16'($urandom), (i == 5));
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL same_edge %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (bus.rows_avail !== 3'd1 || bus.full !== 1'b0) begin
            fails++;
            $display("FAIL same_edge_avail: got avail=%0d full=%b expected 1 0", bus.rows_avail, bus.full);
        end
    endtask

    task automatic test_reset_mid_row();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b1, 16'($urandom), 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        act_ready = bus.in_ready;
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_mid_row: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b1, 16'($urandom), 1'b0);
        tests++;
        if (obs_vec() !== exp_vec() || bus.wr_addr !== 8'd16) begin
            fails++;
            $display("FAIL reset_restart: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL underflow %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
`ifdef ROW_BUF_ERR_CHECK_EN
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL underflow_err: got %b expected 1", err);
        end
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL underflow_err_clear: got %b expected 0", err);
        end
`endif
    endtask

    task automatic test_toggle();
        int pulses;
        pulses = 0;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, (i % 2 == 0) && (i < 12), 16'($urandom), 1'b0);
            if (bus.row_done === 1'b1) pulses++;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL toggle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (pulses != 2 || bus.wr_addr !== 8'd21) begin
            fails++;
            $display("FAIL toggle_rows: got pulses=%0d last=%0d expected 2 21", pulses, bus.wr_addr);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), ($urandom_range(0, 3) == 0));
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
`ifdef ROW_BUF_ERR_CHECK_EN
            tests++;
            if (err !== err_m) begin
                fails++;
                $display("FAIL random_err %0d: got %b expected %b", i, err, err_m);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_fill();
        test_same_edge();
        test_reset_mid_row();
        test_underflow();
        test_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
